// File: rtl/fixed_point_pkg.sv
// Shared constants and types for the sign-magnitude Q7.8 arithmetic units.
package fixed_point_pkg;
  localparam int SIGN   = 15;
  localparam int INT_W  = 7;
  localparam int FRAC_W = 8;
  localparam int MAG_W  = INT_W + FRAC_W;   // 15-bit magnitude
  localparam int WORD_W = MAG_W + 1;
  localparam int DVD_W  = MAG_W + FRAC_W;   // pre-scaled dividend / raw quotient
  localparam int REM_W  = MAG_W + 1;        // one spare bit so the compare never wraps
  localparam int CNT_W  = 5;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  localparam logic [MAG_W-1:0] SAT_MAG  = 15'h7FFF;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DVD_W - 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/fixed_point_divider_if.sv
// Operand/result handshake bundle for the Q7.8 divider.
interface fixed_point_divider_if;
  import fixed_point_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] din_a;
  logic [WORD_W-1:0] din_b;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] dout;
  logic              div0;
  logic              ovf;

  modport master (output in_valid, din_a, din_b, out_ready,
                  input  in_ready, out_valid, dout, div0, ovf);
  modport slave  (input  in_valid, din_a, din_b, out_ready,
                  output in_ready, out_valid, dout, div0, ovf);
endinterface

// File: rtl/fixed_point_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module fixed_point_div_step
  import fixed_point_pkg::*;
(
  input  logic [REM_W-1:0] rem,
  input  logic             dvd_msb,
  input  logic [MAG_W-1:0] mag_b,
  output logic [REM_W-1:0] rem_nxt,
  output logic             q_bit
);
  logic [REM_W-1:0] shifted;
  logic [REM_W-1:0] divisor;

  assign shifted = {rem[REM_W-2:0], dvd_msb};
  assign divisor = {1'b0, mag_b};
  assign q_bit   = (shifted >= divisor);
  assign rem_nxt = q_bit ? (shifted - divisor) : shifted;
endmodule

// File: rtl/fixed_point_divider.sv
// Sequential sign-magnitude Q7.8 divider, one quotient bit per cycle, saturating.
module fixed_point_divider
  import fixed_point_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  fixed_point_divider_if.slave  bus
);
  state_t            state, state_nxt;
  logic              sign_q;
  logic [MAG_W-1:0]  mag_b_q;
  logic [DVD_W-1:0]  dvd_q, quo_q, quo_nxt;
  logic [REM_W-1:0]  rem_q, rem_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] dout_q;
  logic              div0_q, ovf_q;
  logic              accept, q_bit, res_ovf;
  logic [MAG_W-1:0]  res_mag;

  assign accept = (state == IDLE) && bus.in_valid;

  fixed_point_div_step u_step (
    .rem     (rem_q),
    .dvd_msb (dvd_q[DVD_W-1]),
    .mag_b   (mag_b_q),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign quo_nxt = {quo_q[DVD_W-2:0], q_bit};

  always_comb begin
    res_ovf = (quo_nxt[DVD_W-1:MAG_W] != '0);
    res_mag = res_ovf ? SAT_MAG : quo_nxt[MAG_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // A zero divisor is resolved in the first DIV cycle so the result lands one edge after accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = DIV;
      DIV:     if (mag_b_q == '0 || cnt_q == '0) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q  <= 1'b0;
      mag_b_q <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      sign_q  <= bus.din_a[SIGN] ^ bus.din_b[SIGN];
      mag_b_q <= bus.din_b[MAG_W-1:0];
      dvd_q   <= {bus.din_a[MAG_W-1:0], {FRAC_W{1'b0}}};
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= LAST_BIT;
    end else if (state == DIV) begin
      if (mag_b_q == '0) begin
        dout_q <= {sign_q, SAT_MAG};
        div0_q <= 1'b1;
        ovf_q  <= 1'b0;
      end else begin
        rem_q <= rem_nxt;
        dvd_q <= {dvd_q[DVD_W-2:0], 1'b0};
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Zero magnitude never carries a sign.
          dout_q <= {sign_q && (res_mag != '0), res_mag};
          div0_q <= 1'b0;
          ovf_q  <= res_ovf;
        end
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.dout      = dout_q;
  assign bus.div0      = div0_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fixed_point_divider.sv
// Randomized and directed bench for fixed_point_divider against an arithmetic reference.
module tb_fixed_point_divider;
  logic clk, rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  fixed_point_divider_if bus();

  fixed_point_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division of scaled magnitudes, then saturation and sign rules.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic d0, output logic ov, output int lat);
    logic [31:0] ma, mb, qq, m;
    logic        s;
    ma = {17'd0, a[14:0]};
    mb = {17'd0, b[14:0]};
    s  = a[15] ^ b[15];
    if (mb == 0) begin
      q = {s, 15'h7FFF}; d0 = 1'b1; ov = 1'b0; lat = 1;
    end else begin
      qq = (ma * 256) / mb;
      ov = (qq > 32'd32767);
      m  = ov ? 32'd32767 : qq;
      q  = {s && (m != 0), m[14:0]};
      d0 = 1'b0; lat = 23;
    end
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit backpressure);
    logic [15:0] eq;
    logic        ed0, eov;
    int          elat, n;
    model(a, b, eq, ed0, eov, elat);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.din_a = a;
    bus.din_b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.din_a = 16'($urandom);
    bus.din_b = 16'($urandom);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(elat));
    chk("dout", 32'(bus.dout), 32'(eq));
    chk("div0", 32'(bus.div0), 32'(ed0));
    chk("ovf", 32'(bus.ovf), 32'(eov));
    if (backpressure) begin
      for (int i = 0; i < 10; i++) begin
        bus.in_valid = 1'($urandom);
        bus.din_a = 16'($urandom);
        bus.din_b = 16'($urandom);
        @(posedge clk); #1;
        chk("bp_dout", 32'(bus.dout), 32'(eq));
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("in_ready_back", 32'(bus.in_ready), 32'd1);
    chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_dout"}, 32'(bus.dout), 32'd0);
    chk({tag, "_div0"}, 32'(bus.div0), 32'd0);
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
  endtask

  logic [15:0] dir_a [8] = '{16'h0300, 16'h8100, 16'h0100, 16'h0100,
                             16'h7F00, 16'h8000, 16'h0080, 16'h0000};
  logic [15:0] dir_b [8] = '{16'h0200, 16'h0400, 16'h0300, 16'h0000,
                             16'h0001, 16'h8100, 16'h8080, 16'h8000};

  initial begin
    logic [15:0] a, b;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.din_a = '0;
    bus.din_b = '0;
    #1 chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op(dir_a[i], dir_b[i], 1'b0);

    run_op(16'h0300, 16'h0200, 1'b1);
    run_op(16'h8500, 16'h0300, 1'b0);

    // Abandon a transaction mid-DIV.
    bus.in_valid = 1'b1;
    bus.din_a = 16'h0300;
    bus.din_b = 16'h0200;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("post_rst");
    run_op(16'h0300, 16'h0200, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 5))
        0: b[14:0] = '0;
        1: b[14:0] = 15'($urandom_range(1, 4));
        2: a[14:0] = '0;
        default: ;
      endcase
      run_op(a, b, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
